vram_access_arbiter: RTL



---
 rtl/vram_access_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter
// Single-port VRAM sequencer shared by the display line fetcher and the
// CPU write path. A horizontal sync pulse starts a fetch of the next visible
// line into the line buffer. A waiting CPU write is given one slot after
// every BURST_LEN reads, so both requesters keep making progress.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | no VRAM access; waits for a fetch trigger or a CPU request
// S_FETCH  | one line-fetch read per cycle at base_q + col_q
// S_CPU_WR | one-cycle CPU write; afterwards back to S_FETCH if pending_q
//
// Ports:
//   clk, reset           pixel clock, synchronous active-low reset
//   h_sync_pulse, v_addr fetch trigger and current line from timing gen
//   cpu_req/addr/wdata   CPU write request (held until cpu_ack)
//   cpu_ack              one-cycle pulse, write performed in that cycle
//   mem_en/we/addr/wdata VRAM access port, mem_rdata read data (latency 1)
//   lb_we/waddr/wdata    line buffer write port
//   fetch_busy           a line fetch is in progress
//   fetch_overrun        pulse when a running fetch is aborted by a trigger
module vram_access_arbiter #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int V_SUM      = 628,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h_sync_pulse,
    input  logic [9:0]            v_addr,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  lb_we,
    output logic [9:0]            lb_waddr,
    output logic [DATA_WIDTH-1:0] lb_wdata,
    output logic                  fetch_busy,
    output logic                  fetch_overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_CPU_WR = 2'd2;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [9:0]    COL_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    LINE_LAST  = 10'(V_SUM - 1);

    logic [1:0]            state_q, state_d;
    logic [9:0]            col_q, col_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [9:0]            rd_col_q, rd_col_d;
    logic                  overrun_q, overrun_d;

    logic [10:0]           v_next;
    logic                  trig_valid;
    logic [9:0]            target;
    logic [ADDR_WIDTH-1:0] base_new;
    logic                  busy;

    // Next line to prefetch: wraps from the last blanking line to line 0,
    // and lines that would land in vertical blanking start nothing.
    assign v_next     = {1'b0, v_addr} + 11'd1;
    assign trig_valid = h_sync_pulse &&
                        ((v_addr == LINE_LAST) || (v_next < 11'(V_ACTIVE)));
    assign target     = (v_addr == LINE_LAST) ? 10'd0 : v_next[9:0];
    assign base_new   = ADDR_WIDTH'(target) * ADDR_WIDTH'(H_ACTIVE);

    // Busy also covers CPU slots taken mid-fetch and the trailing lb write.
    assign busy = (state_q == S_FETCH) || pending_q || rd_vld_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        burst_d   = burst_q;
        pending_d = 1'b0;
        base_d    = base_q;
        rd_vld_d  = (state_q == S_FETCH);
        rd_col_d  = (state_q == S_FETCH) ? col_q : 10'd0;
        overrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) state_d = S_CPU_WR;
            end
            S_FETCH: begin
                col_d   = col_q + 10'd1;
                burst_d = (burst_q == BURST_LAST) ? '0 : burst_q + 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = cpu_req ? S_CPU_WR : S_IDLE;
                    col_d   = 10'd0;
                    burst_d = '0;
                end else if ((burst_q == BURST_LAST) && cpu_req) begin
                    state_d   = S_CPU_WR;
                    pending_d = 1'b1;
                end
            end
            S_CPU_WR: begin
                state_d = pending_q ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A valid trigger overrides everything: the CPU write in this cycle
        // (if any) still completes, and the new line starts next cycle.
        if (trig_valid) begin
            state_d   = S_FETCH;
            pending_d = 1'b0;
            base_d    = base_new;
            col_d     = 10'd0;
            burst_d   = '0;
            overrun_d = busy;
            if (busy) rd_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            col_q     <= 10'd0;
            burst_q   <= '0;
            pending_q <= 1'b0;
            base_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_col_q  <= 10'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            burst_q   <= burst_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            rd_vld_q  <= rd_vld_d;
            rd_col_q  <= rd_col_d;
            overrun_q <= overrun_d;
        end
    end

    assign cpu_ack   = (state_q == S_CPU_WR);
    assign mem_en    = (state_q == S_FETCH) || (state_q == S_CPU_WR);
    assign mem_we    = (state_q == S_CPU_WR);
    assign mem_addr  = (state_q == S_CPU_WR) ? cpu_addr :
                       (state_q == S_FETCH)  ? base_q + ADDR_WIDTH'(col_q) : '0;
    assign mem_wdata = (state_q == S_CPU_WR) ? cpu_wdata : '0;

    assign lb_we         = rd_vld_q;
    assign lb_waddr      = rd_col_q;
    assign lb_wdata      = rd_vld_q ? mem_rdata : '0;
    assign fetch_busy    = busy;
    assign fetch_overrun = overrun_q;

endmodule
